// File: rtl/seq_div_sub_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master side issues requests; the slave side (the divider) returns results.
interface seq_div_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_sub.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, MSB first.
// Each trial subtraction is done as P' + ~D + 1; carry-out high means P' >= D.
module seq_div_sub #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_div_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;

    logic             busy_r, done_r, dbz_r;
    logic [WIDTH-1:0] quo_r, rem_r;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH+1:0] sum;
    logic             cout;
    logic [WIDTH:0]   p_nxt;
    logic [WIDTH-1:0] q_nxt;

    // Trial subtraction, one bit wider than P so the carry-out is the no-borrow flag
    always_comb begin
        p_sh  = {p[WIDTH-1:0], dvd[WIDTH-1]};
        sum   = {1'b0, p_sh} + {1'b0, ~{1'b0, dvs}} + (WIDTH+2)'(1);
        cout  = sum[WIDTH+1];
        p_nxt = cout ? sum[WIDTH:0] : p_sh;
        q_nxt = {q[WIDTH-2:0], cout};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            p      <= '0;
            q      <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            quo_r  <= '0;
            rem_r  <= '0;
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            quo_r  <= '1;
                            rem_r  <= bus.dividend;
                            dbz_r  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                            dvd    <= bus.dividend;
                            dvs    <= bus.divisor;
                            p      <= '0;
                            q      <= '0;
                            cnt    <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    p   <= p_nxt;
                    q   <= q_nxt;
                    dvd <= dvd << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        quo_r  <= q_nxt;
                        rem_r  <= p_nxt[WIDTH-1:0];
                        dbz_r  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_div_sub.sv
// Bench for seq_div_sub: directed scenarios, random operands and an exhaustive
// sweep, all checked against plain integer division.
module tb_seq_div_sub;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seq_div_sub_if #(.WIDTH(W)) bus ();

    seq_div_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: integer division; zero divisor yields all-ones / dividend / flag
    task automatic model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << W) - 1; r = a; z = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Caller is in cycle 0; drives start, scrambles operands after acceptance,
    // waits (bounded) for done. lat = cycle of done, or -1 on timeout.
    task automatic run_op(input int a, input int b, output int q, output int r, output int z,
                          output int lat, output int nbusy, output int overlap);
        bus.start = 1'b1; bus.dividend = W'(a); bus.divisor = W'(b);
        lat = -1; nbusy = 0; overlap = 0; q = 0; r = 0; z = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 1) begin
                bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
            end
            if (bus.busy) nbusy++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                lat = c; q = int'(bus.quotient); r = int'(bus.remainder); z = int'(bus.div_by_zero);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            bad++; $display("FAIL reset_results got q=%0d r=%0d z=%b want 0 0 0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int as[4] = '{13, 15, 7, 0};
        int bs[4] = '{3, 1, 9, 5};
        int q, r, z, lat, nb, ov, eq, er, ez;
        for (int i = 0; i < 4; i++) begin
            model(as[i], bs[i], eq, er, ez);
            run_op(as[i], bs[i], q, r, z, lat, nb, ov);
            total++; if (lat != W + 1 || nb != W || ov != 0) begin
                bad++; $display("FAIL basic_timing %0d/%0d got lat=%0d busy=%0d ov=%0d want lat=%0d busy=%0d ov=0", as[i], bs[i], lat, nb, ov, W + 1, W);
            end
            total++; if (q != eq || r != er || z != ez) begin
                bad++; $display("FAIL basic_result %0d/%0d got q=%0d r=%0d z=%0d want q=%0d r=%0d z=%0d", as[i], bs[i], q, r, z, eq, er, ez);
            end
            step();
        end
    endtask

    task automatic test_div_zero();
        int q, r, z, lat, nb, ov;
        run_op(9, 0, q, r, z, lat, nb, ov);
        total++; if (lat != 1 || nb != 0) begin
            bad++; $display("FAIL divzero_timing got lat=%0d busy=%0d want lat=1 busy=0", lat, nb);
        end
        total++; if (q != 15 || r != 9 || z != 1) begin
            bad++; $display("FAIL divzero_result got q=%0d r=%0d z=%0d want q=15 r=9 z=1", q, r, z);
        end
        step();
        total++; if (bus.done !== 1'b0 || bus.quotient !== 4'd15 || bus.div_by_zero !== 1'b1) begin
            bad++; $display("FAIL divzero_hold got done=%b q=%0d z=%b want done=0 q=15 z=1", bus.done, bus.quotient, bus.div_by_zero);
        end
    endtask

    // Previous result is still q=15 r=9 z=1 from the zero-divisor test
    task automatic test_start_while_busy();
        int lat = -1;
        bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
        for (int c = 1; c <= 40; c++) begin
            step();
            bus.start = (c == 2);
            if (c == 2) begin bus.dividend = 4'd15; bus.divisor = 4'd2; end
            if (c == 1) begin
                total++; if (bus.quotient !== 4'd15 || bus.remainder !== 4'd9 || bus.div_by_zero !== 1'b1) begin
                    bad++; $display("FAIL hold_prev got q=%0d r=%0d z=%b want q=15 r=9 z=1", bus.quotient, bus.remainder, bus.div_by_zero);
                end
            end
            if (bus.done) begin lat = c; break; end
        end
        bus.start = 1'b0;
        total++; if (lat != 5 || bus.quotient !== 4'd2 || bus.remainder !== 4'd2) begin
            bad++; $display("FAIL busy_ignore got lat=%0d q=%0d r=%0d want lat=5 q=2 r=2", lat, bus.quotient, bus.remainder);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int q, r, z, lat, nb, ov, seen = 0;
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
        step(); bus.start = 1'b0;
        step();
        step(); rst = 1'b1;
        step();
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            bad++; $display("FAIL reset_mid got busy=%b done=%b q=%0d r=%0d z=%b want all 0", bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin step(); if (bus.done || bus.busy) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL reset_no_done got activity=%0d want 0", seen); end
        run_op(6, 4, q, r, z, lat, nb, ov);
        total++; if (lat != 5 || q != 1 || r != 2 || z != 0) begin
            bad++; $display("FAIL after_reset got lat=%0d q=%0d r=%0d z=%0d want lat=5 q=1 r=2 z=0", lat, q, r, z);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int q, r, z, lat, nb, ov;
        run_op(10, 3, q, r, z, lat, nb, ov);
        total++; if (lat != 5 || q != 3 || r != 1) begin
            bad++; $display("FAIL b2b_first got lat=%0d q=%0d r=%0d want lat=5 q=3 r=1", lat, q, r);
        end
        run_op(11, 4, q, r, z, lat, nb, ov);
        total++; if (lat != 5 || q != 2 || r != 3 || ov != 0) begin
            bad++; $display("FAIL b2b_second got lat=%0d q=%0d r=%0d ov=%0d want lat=5 q=2 r=3 ov=0", lat, q, r, ov);
        end
        step();
    endtask

    task automatic test_random();
        int a, b, q, r, z, lat, nb, ov, eq, er, ez, elat;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            model(a, b, eq, er, ez);
            elat = (b == 0) ? 1 : W + 1;
            run_op(a, b, q, r, z, lat, nb, ov);
            total++; if (lat != elat || q != eq || r != er || z != ez || ov != 0) begin
                bad++; $display("FAIL random %0d/%0d got lat=%0d q=%0d r=%0d z=%0d want lat=%0d q=%0d r=%0d z=%0d", a, b, lat, q, r, z, elat, eq, er, ez);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_sweep();
        int q, r, z, lat, nb, ov;
        int errs = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op(a, b, q, r, z, lat, nb, ov);
                if (lat < 0 || ov != 0) errs++;
                else if (b != 0 && (a != q * b + r || r >= b || z != 0)) errs++;
                else if (b == 0 && (q != (1 << W) - 1 || r != a || z != 1)) errs++;
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL sweep got errors=%0d want 0", errs); end
        step();
    endtask

    initial begin
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
